// File: rtl/time_of_day_counter_if.sv
// time_of_day_counter_if: button/tick inputs and BCD time/mode/alarm outputs of the time-of-day counter.
interface time_of_day_counter_if;
    logic       tick_in;
    logic       mode_btn;
    logic       inc_btn;
    logic [1:0] hr_t;
    logic [3:0] hr_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic [1:0] mode;
    logic       alarm_out;
    modport master (
        output tick_in, mode_btn, inc_btn,
        input  hr_t, hr_u, min_t, min_u, sec_t, sec_u, mode, alarm_out
    );
    modport slave (
        input  tick_in, mode_btn, inc_btn,
        output hr_t, hr_u, min_t, min_u, sec_t, sec_u, mode, alarm_out
    );
endinterface

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: BCD HH:MM:SS clock with synchronized tick/mode/inc edge inputs and set modes.
// Define ALARM_EN to add the SET_AL state, 15-minute-step alarm registers and alarm_out.
module time_of_day_counter #(
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    time_of_day_counter_if.slave bus
);
    localparam int WW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
`ifdef ALARM_EN
        , SET_AL = 2'd3
`endif
    } state_t;

    function automatic logic [5:0] hr_inc(input logic [1:0] t, input logic [3:0] u);
        return (t == 2'd2 && u == 4'd3) ? 6'd0 : (u == 4'd9) ? {t + 2'd1, 4'd0} : {t, u + 4'd1};
    endfunction

    function automatic logic [6:0] ms_inc(input logic [2:0] t, input logic [3:0] u);
        return (t == 3'd5 && u == 4'd9) ? 7'd0 : (u == 4'd9) ? {t + 3'd1, 4'd0} : {t, u + 4'd1};
    endfunction

    logic [SYNC_STAGES-1:0] r_tick_s, r_mode_s, r_inc_s;
    logic [2:0]             r_prev, r_armed;
    logic [WW-1:0]          r_warm;
    logic [2:0]             w_last, w_pulse;
    logic                   w_warm;
    state_t                 r_state;
    logic [1:0]             r_hr_t;
    logic [3:0]             r_hr_u, r_min_u, r_sec_u;
    logic [2:0]             r_min_t, r_sec_t;
    logic [5:0]             w_hr_n;
    logic [6:0]             w_min_n, w_sec_n;
    logic                   w_sec_wrap, w_min_wrap;

    // Pulse bits: 0 tick, 1 mode, 2 inc
    assign w_last  = {r_inc_s[SYNC_STAGES-1], r_mode_s[SYNC_STAGES-1], r_tick_s[SYNC_STAGES-1]};
    assign w_warm  = r_warm == WW'(SYNC_STAGES);
    assign w_pulse = w_last & ~r_prev & r_armed;

    assign w_hr_n     = hr_inc(r_hr_t, r_hr_u);
    assign w_min_n    = ms_inc(r_min_t, r_min_u);
    assign w_sec_n    = ms_inc(r_sec_t, r_sec_u);
    assign w_sec_wrap = r_sec_t == 3'd5 && r_sec_u == 4'd9;
    assign w_min_wrap = r_min_t == 3'd5 && r_min_u == 4'd9;

`ifdef ALARM_EN
    logic [1:0] r_al_hr_t;
    logic [3:0] r_al_hr_u;
    logic [1:0] r_al_q;
    logic [2:0] w_al_min_t;
    logic [3:0] w_al_min_u;
    assign w_al_min_t = (r_al_q == 2'd0) ? 3'd0 : (r_al_q == 2'd1) ? 3'd1 : (r_al_q == 2'd2) ? 3'd3 : 3'd4;
    assign w_al_min_u = r_al_q[0] ? 4'd5 : 4'd0;
    assign bus.alarm_out = r_state == RUN && r_hr_t == r_al_hr_t && r_hr_u == r_al_hr_u &&
                           r_min_t == w_al_min_t && r_min_u == w_al_min_u;
`else
    assign bus.alarm_out = 1'b0;
`endif

    // Edge detectors arm only after a genuine low sample, so a level held across reset is not a press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_s <= '0;
            r_mode_s <= '0;
            r_inc_s  <= '0;
            r_prev   <= '0;
            r_armed  <= '0;
            r_warm   <= '0;
            r_state  <= RUN;
            {r_hr_t, r_hr_u, r_min_t, r_min_u, r_sec_t, r_sec_u} <= '0;
`ifdef ALARM_EN
            r_al_hr_t <= 2'd0;
            r_al_hr_u <= 4'd6;
            r_al_q    <= 2'd0;
`endif
        end else begin
            r_tick_s <= {r_tick_s[SYNC_STAGES-2:0], bus.tick_in};
            r_mode_s <= {r_mode_s[SYNC_STAGES-2:0], bus.mode_btn};
            r_inc_s  <= {r_inc_s[SYNC_STAGES-2:0], bus.inc_btn};
            r_prev   <= w_last;
            r_armed  <= r_armed | (w_warm ? ~w_last : 3'b000);
            if (!w_warm) r_warm <= r_warm + 1'b1;
            case (r_state)
                RUN: begin
                    if (w_pulse[1]) begin
                        r_state <= SET_HR;
                        {r_sec_t, r_sec_u} <= '0;
                    end else if (w_pulse[0]) begin
                        {r_sec_t, r_sec_u} <= w_sec_n;
                        if (w_sec_wrap) begin
                            {r_min_t, r_min_u} <= w_min_n;
                            if (w_min_wrap) {r_hr_t, r_hr_u} <= w_hr_n;
                        end
                    end
                end
                SET_HR: begin
                    if (w_pulse[2]) {r_hr_t, r_hr_u} <= w_hr_n;
                    if (w_pulse[1]) r_state <= SET_MIN;
                end
                SET_MIN: begin
                    if (w_pulse[2]) {r_min_t, r_min_u} <= w_min_n;
`ifdef ALARM_EN
                    if (w_pulse[1]) r_state <= SET_AL;
`else
                    if (w_pulse[1]) r_state <= RUN;
`endif
                end
`ifdef ALARM_EN
                SET_AL: begin
                    if (w_pulse[2]) begin
                        r_al_q <= r_al_q + 2'd1;
                        if (r_al_q == 2'd3) {r_al_hr_t, r_al_hr_u} <= hr_inc(r_al_hr_t, r_al_hr_u);
                    end
                    if (w_pulse[1]) r_state <= RUN;
                end
`endif
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.hr_t  = r_hr_t;
    assign bus.hr_u  = r_hr_u;
    assign bus.min_t = r_min_t;
    assign bus.min_u = r_min_u;
    assign bus.sec_t = r_sec_t;
    assign bus.sec_u = r_sec_u;
    assign bus.mode  = r_state;
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: randomized + directed scoreboard bench against a seconds-of-day reference model.
module tb_time_of_day_counter;
`ifdef ALARM_EN
    localparam bit AL_EN = 1'b1;
`else
    localparam bit AL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    time_of_day_counter_if bus();
    time_of_day_counter #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          due;
        logic [22:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    item_t it;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit started = 0;
    int m_t, m_mode, m_am;
    logic [22:0] act_v;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [22:0] pack_exp();
        int h, mi, s;
        bit al;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        al = AL_EN && m_mode == 0 && (m_t / 60) == m_am;
        return {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10), 2'(m_mode), al};
    endfunction

    task automatic push(input string name, input int lat);
        q.push_back('{cyc + lat, pack_exp(), name});
    endtask

    assign act_v = {bus.hr_t, bus.hr_u, bus.min_t, bus.min_u, bus.sec_t, bus.sec_u, bus.mode, bus.alarm_out};

    always @(negedge clk) begin
        if (started) begin
            tests++;
            if (bus.hr_t > 2 || bus.hr_u > 9 || (bus.hr_t == 2 && bus.hr_u > 3) || bus.min_t > 5 ||
                bus.min_u > 9 || bus.sec_t > 5 || bus.sec_u > 9 || (!AL_EN && bus.mode == 2'd3)) begin
                fails++;
                $display("FAIL digit_range: got %h at cycle %0d, required all BCD digits and mode in range", act_v, cyc);
            end
        end
        while (q.size() > 0 && q[0].due <= cyc) begin
            it = q.pop_front();
            tests++;
            if (act_v !== it.exp) begin
                fails++;
                $display("FAIL %s: got %h required %h (hr_t,hr_u,min_t,min_u,sec_t,sec_u,mode,alarm) cycle %0d",
                         it.name, act_v, it.exp, cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_step(input bit t, input bit m, input bit i);
        int h, mi;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        if (m_mode == 0) begin
            if (m) begin
                m_mode = 1;
                m_t    = m_t - m_t % 60;
            end else if (t) m_t = (m_t + 1) % 86400;
        end else begin
            if (i && m_mode == 1) m_t = m_t + (((h + 1) % 24) - h) * 3600;
            if (i && m_mode == 2) m_t = m_t + (((mi + 1) % 60) - mi) * 60;
            if (i && m_mode == 3) m_am = (m_am + 15) % 1440;
            if (m) m_mode = (m_mode == 1) ? 2 : (m_mode == 2 && AL_EN) ? 3 : 0;
        end
    endtask

    task automatic act(input bit t, input bit m, input bit i, input string name);
        bus.tick_in  = t;
        bus.mode_btn = m;
        bus.inc_btn  = i;
        model_step(t, m, i);
        push(name, 3);
        idle($urandom_range(1, 4));
        bus.tick_in  = 1'b0;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        idle(3);
    endtask

    task automatic do_reset(input string name);
        rst    = 1'b1;
        m_t    = 0;
        m_mode = 0;
        m_am   = 360;
        push(name, 1);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
    endtask

    task automatic ticks(input int n, input string name);
        repeat (n) act(1'b1, 1'b0, 1'b0, name);
    endtask

    task automatic to_mode(input int md);
        while (m_mode != md) act(1'b0, 1'b1, 1'b0, "mode_press");
    endtask

    task automatic set_time(input int h, input int mi);
        to_mode(1);
        while (m_t / 3600 != h) act(1'b0, 1'b0, 1'b1, "inc_hr");
        to_mode(2);
        while ((m_t / 60) % 60 != mi) act(1'b0, 1'b0, 1'b1, "inc_min");
        to_mode(0);
    endtask

    initial begin
        bus.tick_in  = 1'b0;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        @(negedge clk);
        started = 1;
        do_reset("reset_state");
        ticks(61, "run_61_ticks");
        act(1'b0, 1'b0, 1'b1, "inc_ignored_in_run");
        set_time(23, 59);
        ticks(60, "midnight_wrap");
        set_time(12, 34);
        ticks(56, "to_12_34_56");
        act(1'b0, 1'b1, 1'b0, "enter_set_hr");
        repeat (13) act(1'b0, 1'b0, 1'b1, "set_hr_inc");
        act(1'b0, 1'b1, 1'b0, "enter_set_min");
        repeat (30) act(1'b0, 1'b0, 1'b1, "set_min_inc");
        ticks(2, "tick_frozen_in_set");
        to_mode(0);
        set_time(10, 0);
        ticks(30, "to_10_00_30");
        act(1'b1, 1'b1, 1'b0, "tick_mode_same_edge");
        act(1'b0, 1'b1, 1'b1, "inc_mode_same_edge");
        to_mode(0);
        if (AL_EN) begin
            do_reset("alarm_reset");
            to_mode(1);
            repeat (6) act(1'b0, 1'b0, 1'b1, "al_inc_hr");
            to_mode(2);
            repeat (59) act(1'b0, 1'b0, 1'b1, "al_inc_min");
            to_mode(3);
            repeat (4) act(1'b0, 1'b0, 1'b1, "al_set_alarm");
            to_mode(0);
            ticks(120, "alarm_window");
        end
        do_reset("held_reset_pre");
        to_mode(2);
        bus.tick_in = 1'b1;
        idle(4);
        do_reset("reset_in_set_min");
        idle(3);
        push("held_tick_no_count", 1);
        idle(2);
        bus.tick_in = 1'b0;
        idle(3);
        act(1'b1, 1'b0, 1'b0, "tick_after_release");
        repeat (300) begin
            if ($urandom_range(0, 99) < 3) do_reset("rand_reset");
            else begin
                bit t, m, i;
                t = 1'($urandom_range(0, 1));
                m = $urandom_range(0, 3) == 0;
                i = 1'($urandom_range(0, 1));
                if (!t && !m && !i) t = 1'b1;
                act(t, m, i, "random");
            end
        end
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d checks pending, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
